// File: rtl/cubehash_pkg.sv
// ============================================================================
// Module      : cubehash_pkg
// Description : Shared constants, FSM encoding and helpers for the CubeHash core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cubehash_pkg;

    localparam int STATE_W = 1024;
    localparam int WORD_W  = 32;
    localparam int NWORDS  = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INIT     = 3'd1,
        WAIT_MSG = 3'd2,
        ABSORB   = 3'd3,
        FINAL    = 3'd4,
        DONE     = 3'd5
    } state_t;

    // Pre-IV state: word0 = h/8, word1 = b, word2 = r, all other words zero.
    function automatic logic [STATE_W-1:0] init_state(input int unsigned h,
                                                      input int unsigned b,
                                                      input int unsigned r);
        logic [STATE_W-1:0] s;
        s = '0;
        s[STATE_W-1          -: WORD_W] = 32'(h / 8);
        s[STATE_W-1-WORD_W   -: WORD_W] = 32'(b);
        s[STATE_W-1-2*WORD_W -: WORD_W] = 32'(r);
        return s;
    endfunction

    function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] x,
                                                 input int unsigned n);
        return (x << n) | (x >> (WORD_W - n));
    endfunction

endpackage

`default_nettype wire

// File: rtl/cubehash_if.sv
// ============================================================================
// Module      : cubehash_if
// Description : Host message / digest interface of the CubeHash core.
//               iv_load and iv exist only with CUBEHASH_IV_PRELOAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cubehash_if #(
    parameter int B = 32,
    parameter int H = 512
);
    import cubehash_pkg::*;

    logic             start;
    logic             msg_valid;
    logic             msg_ready;
    logic             msg_last;
    logic [B*8-1:0]   msg;
    logic             busy;
    logic             digest_valid;
    logic [H-1:0]     digest;
`ifdef CUBEHASH_IV_PRELOAD_EN
    logic             iv_load;
    logic [STATE_W-1:0] iv;

    modport master (output start, msg_valid, msg_last, msg, iv_load, iv,
                    input  msg_ready, busy, digest_valid, digest);
    modport slave  (input  start, msg_valid, msg_last, msg, iv_load, iv,
                    output msg_ready, busy, digest_valid, digest);
`else
    modport master (output start, msg_valid, msg_last, msg,
                    input  msg_ready, busy, digest_valid, digest);
    modport slave  (input  start, msg_valid, msg_last, msg,
                    output msg_ready, busy, digest_valid, digest);
`endif

endinterface

`default_nettype wire

// File: rtl/cubehash_rounds.sv
// ============================================================================
// Module      : cubehash_round / cubehash_rounds
// Description : Single combinational CubeHash round, and a chain of UNROLL
//               rounds evaluated in one clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cubehash_round
    import cubehash_pkg::*;
(
    input  wire logic [STATE_W-1:0] din,
    output logic      [STATE_W-1:0] dout
);

    logic [WORD_W-1:0] w_x [NWORDS];
    logic [WORD_W-1:0] w_t [16];

    // Swaps are written as gather permutations through w_t.
    always_comb begin
        w_t  = '{default: '0};
        dout = '0;
        for (int i = 0; i < NWORDS; i++) w_x[i] = din[STATE_W-1-WORD_W*i -: WORD_W];

        for (int i = 0; i < 16; i++) w_x[16+i] = w_x[16+i] + w_x[i];
        for (int i = 0; i < 16; i++) w_x[i]    = rotl32(w_x[i], 7);
        for (int i = 0; i < 16; i++) w_t[i]    = w_x[i ^ 8];
        for (int i = 0; i < 16; i++) w_x[i]    = w_t[i] ^ w_x[16+i];
        for (int i = 0; i < 16; i++) w_t[i]    = w_x[16 + (i ^ 2)];
        for (int i = 0; i < 16; i++) w_x[16+i] = w_t[i];

        for (int i = 0; i < 16; i++) w_x[16+i] = w_x[16+i] + w_x[i];
        for (int i = 0; i < 16; i++) w_x[i]    = rotl32(w_x[i], 11);
        for (int i = 0; i < 16; i++) w_t[i]    = w_x[i ^ 4];
        for (int i = 0; i < 16; i++) w_x[i]    = w_t[i] ^ w_x[16+i];
        for (int i = 0; i < 16; i++) w_t[i]    = w_x[16 + (i ^ 1)];
        for (int i = 0; i < 16; i++) w_x[16+i] = w_t[i];

        for (int i = 0; i < NWORDS; i++) dout[STATE_W-1-WORD_W*i -: WORD_W] = w_x[i];
    end

endmodule

module cubehash_rounds
    import cubehash_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  wire logic [STATE_W-1:0] din,
    output logic      [STATE_W-1:0] dout
);

    logic [STATE_W-1:0] w_stage [UNROLL+1];

    assign w_stage[0] = din;

    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        cubehash_round u_round (
            .din  (w_stage[k]),
            .dout (w_stage[k+1])
        );
    end

    assign dout = w_stage[UNROLL];

endmodule

`default_nettype wire

// File: rtl/cubehash_core.sv
// ============================================================================
// Module      : cubehash_core
// Description : Iterative CubeHash-R/B-H engine: IV generation, block absorb
//               and finalization with UNROLL rounds per clock.
//               Optional IV preload enabled by CUBEHASH_IV_PRELOAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cubehash_core
    import cubehash_pkg::*;
#(
    parameter int R      = 16,
    parameter int B      = 32,
    parameter int H      = 512,
    parameter int UNROLL = 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    cubehash_if.slave bus
);

    localparam int c_init_cyc = 10 * R / UNROLL;
    localparam int c_blk_cyc  = R / UNROLL;
    localparam int c_cnt_w    = $clog2(c_init_cyc + 1);
    localparam logic [c_cnt_w-1:0] c_init_cnt = c_cnt_w'(c_init_cyc);
    localparam logic [c_cnt_w-1:0] c_blk_cnt  = c_cnt_w'(c_blk_cyc);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_t             r_fsm;
    logic [STATE_W-1:0] r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_last;
    logic [B*8-1:0]     r_blk;
    logic               r_msg_ready;
    logic               r_busy;
    logic               r_digest_valid;
    logic [H-1:0]       r_digest;

    logic               w_xor_en;
    logic [STATE_W-1:0] w_blk_ext;
    logic [STATE_W-1:0] w_round_in;
    logic [STATE_W-1:0] w_round_out;

    // The captured block is folded into the round input on the first ABSORB cycle.
    assign w_xor_en   = (r_fsm == ABSORB) && (r_cnt == c_blk_cnt);
    assign w_blk_ext  = STATE_W'(r_blk) << (STATE_W - B*8);
    assign w_round_in = w_xor_en ? (r_state ^ w_blk_ext) : r_state;

    cubehash_rounds #(.UNROLL(UNROLL)) u_rounds (
        .din  (w_round_in),
        .dout (w_round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm          <= IDLE;
            r_state        <= '0;
            r_cnt          <= '0;
            r_last         <= 1'b0;
            r_blk          <= '0;
            r_msg_ready    <= 1'b0;
            r_busy         <= 1'b0;
            r_digest_valid <= 1'b0;
            r_digest       <= '0;
        end else begin
            case (r_fsm)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_digest_valid <= 1'b0;
`ifdef CUBEHASH_IV_PRELOAD_EN
                        if (bus.iv_load) begin
                            r_state     <= bus.iv;
                            r_fsm       <= WAIT_MSG;
                            r_msg_ready <= 1'b1;
                        end else begin
`else
                        begin
`endif
                            r_state <= init_state(H, B, R);
                            r_cnt   <= c_init_cnt;
                            r_fsm   <= INIT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                INIT: begin
                    r_state <= w_round_out;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == c_cnt_one) begin
                        r_fsm       <= WAIT_MSG;
                        r_busy      <= 1'b0;
                        r_msg_ready <= 1'b1;
                    end
                end
                WAIT_MSG: begin
                    if (bus.msg_valid && r_msg_ready) begin
                        r_blk       <= bus.msg;
                        r_last      <= bus.msg_last;
                        r_cnt       <= c_blk_cnt;
                        r_fsm       <= ABSORB;
                        r_msg_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ABSORB: begin
                    r_state <= w_round_out;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == c_cnt_one) begin
                        if (r_last) begin
                            // Finalization flag: xor 1 into the last state word.
                            r_state <= w_round_out ^ STATE_W'(1);
                            r_cnt   <= c_init_cnt;
                            r_fsm   <= FINAL;
                        end else begin
                            r_fsm       <= WAIT_MSG;
                            r_busy      <= 1'b0;
                            r_msg_ready <= 1'b1;
                        end
                    end
                end
                FINAL: begin
                    r_state <= w_round_out;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == c_cnt_one) begin
                        r_digest       <= w_round_out[STATE_W-1 -: H];
                        r_fsm          <= DONE;
                        r_busy         <= 1'b0;
                        r_digest_valid <= 1'b1;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign bus.msg_ready    = r_msg_ready;
    assign bus.busy         = r_busy;
    assign bus.digest_valid = r_digest_valid;
    assign bus.digest       = r_digest;

endmodule

`default_nettype wire

// File: tb/tb_cubehash_core.sv
// ============================================================================
// Module      : tb_cubehash_core
// Description : Directed self-checking bench for cubehash_core (16/32/512 with
//               UNROLL=1, and 16/32/256 with UNROLL=4). Honours CUBEHASH_IV_PRELOAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cubehash_core;
    import cubehash_pkg::*;

    logic clk;
    logic rst_n;

    cubehash_if #(.B(32), .H(512)) if0 ();
    cubehash_if #(.B(32), .H(256)) if1 ();

    cubehash_core #(.R(16), .B(32), .H(512), .UNROLL(1)) dut0 (
        .clk (clk), .rst_n (rst_n), .bus (if0.slave)
    );
    cubehash_core #(.R(16), .B(32), .H(256), .UNROLL(4)) dut1 (
        .clk (clk), .rst_n (rst_n), .bus (if1.slave)
    );

    int n_pass   = 0;
    int n_checks = 0;
    logic [255:0] blk [3];
    int           gap [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference CubeHash round, written directly from the swap/add/xor description.
    function automatic logic [1023:0] m_rounds(input logic [1023:0] s_in, input int n);
        logic [31:0] w [32];
        logic [31:0] t;
        logic [1023:0] s;
        for (int i = 0; i < 32; i++) w[i] = s_in[1023-32*i -: 32];
        for (int r = 0; r < n; r++) begin
            for (int i = 0; i < 16; i++) w[i+16] = w[i+16] + w[i];
            for (int i = 0; i < 16; i++) w[i] = {w[i][24:0], w[i][31:25]};
            for (int i = 0; i < 8; i++) begin t = w[i]; w[i] = w[i+8]; w[i+8] = t; end
            for (int i = 0; i < 16; i++) w[i] = w[i] ^ w[i+16];
            for (int i = 16; i < 32; i++)
                if ((i & 2) == 0) begin t = w[i]; w[i] = w[i+2]; w[i+2] = t; end
            for (int i = 0; i < 16; i++) w[i+16] = w[i+16] + w[i];
            for (int i = 0; i < 16; i++) w[i] = {w[i][20:0], w[i][31:21]};
            for (int i = 0; i < 16; i++)
                if ((i & 4) == 0) begin t = w[i]; w[i] = w[i+4]; w[i+4] = t; end
            for (int i = 0; i < 16; i++) w[i] = w[i] ^ w[i+16];
            for (int i = 16; i < 32; i += 2) begin t = w[i]; w[i] = w[i+1]; w[i+1] = t; end
        end
        s = '0;
        for (int i = 0; i < 32; i++) s[1023-32*i -: 32] = w[i];
        return s;
    endfunction

    function automatic logic [1023:0] m_iv(input int h);
        logic [1023:0] s;
        s = '0;
        s[1023 -: 32] = 32'(h / 8);
        s[991  -: 32] = 32'd32;
        s[959  -: 32] = 32'd16;
        return m_rounds(s, 160);
    endfunction

    function automatic logic [511:0] m_digest(input int h, input int nb);
        logic [1023:0] s;
        s = m_iv(h);
        for (int k = 0; k < nb; k++) begin
            s[1023 -: 256] = s[1023 -: 256] ^ blk[k];
            s = m_rounds(s, 16);
        end
        s[0] = ~s[0];
        s = m_rounds(s, 160);
        return s[1023 -: 512];
    endfunction

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int d, input logic st, input logic v, input logic l,
                          input logic [255:0] m);
        if (d == 0) begin
            if0.start = st; if0.msg_valid = v; if0.msg_last = l; if0.msg = m;
        end else begin
            if1.start = st; if1.msg_valid = v; if1.msg_last = l; if1.msg = m;
        end
    endtask

    function automatic logic sig(input int d, input int w);
        case (w)
            0:       return (d == 0) ? if0.msg_ready    : if1.msg_ready;
            1:       return (d == 0) ? if0.digest_valid : if1.digest_valid;
            default: return (d == 0) ? if0.busy         : if1.busy;
        endcase
    endfunction

    function automatic logic [511:0] dig(input int d);
        return (d == 0) ? if0.digest : {256'b0, if1.digest};
    endfunction

    task automatic count_until(input int d, input int w, output int n);
        n = 0;
        while (n < 1000) begin
            tick();
            n++;
            if (sig(d, w)) break;
        end
    endtask

    task automatic run_hash(input int d, input string tag, input int nb,
                            input int ei, input int ea, input int ef);
        int n;
        logic [1023:0] st, iv;
        logic [511:0] tmp, e;
        set_in(d, 1'b1, 1'b0, 1'b0, '0);
        tick();
        set_in(d, 1'b0, 1'b0, 1'b0, '0);
        check({tag, " busy after start"}, 512'(sig(d, 2)), 512'd1);
        count_until(d, 0, n);
        check({tag, " init cycles"}, 512'(n), 512'(ei));
        st = (d == 0) ? dut0.r_state : dut1.r_state;
        iv = m_iv((d == 0) ? 512 : 256);
        check({tag, " iv hi"}, st[1023:512], iv[1023:512]);
        check({tag, " iv lo"}, st[511:0],    iv[511:0]);
        for (int k = 0; k < nb; k++) begin
            repeat (gap[k]) tick();
            set_in(d, 1'b0, 1'b1, (k == nb - 1), blk[k]);
            tick();
            set_in(d, 1'b0, 1'b0, 1'b0, '0);
            check({tag, " ready low in absorb"}, 512'(sig(d, 0)), 512'd0);
            if (k < nb - 1) begin
                count_until(d, 0, n);
                check({tag, " absorb cycles"}, 512'(n), 512'(ea));
            end else begin
                count_until(d, 1, n);
                check({tag, " absorb+final cycles"}, 512'(n), 512'(ea + ef));
            end
        end
        tmp = m_digest((d == 0) ? 512 : 256, nb);
        e   = (d == 0) ? tmp : {256'b0, tmp[511 -: 256]};
        check({tag, " digest"}, dig(d), e);
        check({tag, " busy low in done"}, 512'(sig(d, 2)), 512'd0);
    endtask

    initial begin
        int n;
        logic [511:0] e;
        rst_n = 1'b1;
        set_in(0, 1'b0, 1'b0, 1'b0, '0);
        set_in(1, 1'b0, 1'b0, 1'b0, '0);
`ifdef CUBEHASH_IV_PRELOAD_EN
        if0.iv_load = 1'b0; if0.iv = '0;
        if1.iv_load = 1'b0; if1.iv = '0;
`endif
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("reset ready",  512'(if0.msg_ready),    512'd0);
        check("reset busy",   512'(if0.busy),         512'd0);
        check("reset valid",  512'(if0.digest_valid), 512'd0);
        check("reset digest", if0.digest,             512'd0);
        check("reset u4 valid", 512'(if1.digest_valid), 512'd0);
        rst_n = 1'b1;
        tick();

        blk[0] = {32'h00000080, 224'd0};
        gap = '{0, 0, 0};
        run_hash(0, "empty512", 1, 160, 16, 160);

        blk[0] = {32'h01234567, 32'h89abcdef, 32'hdeadbeef, 32'h00000001,
                  32'hfedcba98, 32'h76543210, 32'h0f0f0f0f, 32'hf0f0f0f0};
        blk[1] = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                  32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        blk[2] = {32'h00806261, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        gap = '{0, 5, 0};
        run_hash(0, "three", 3, 160, 16, 160);

        blk[0] = {32'h00000080, 224'd0};
        gap = '{0, 0, 0};
        run_hash(1, "u4h256", 1, 40, 4, 40);

        // Abort partway through an absorb.
        set_in(0, 1'b1, 1'b0, 1'b0, '0);
        tick();
        set_in(0, 1'b0, 1'b0, 1'b0, '0);
        count_until(0, 0, n);
        set_in(0, 1'b0, 1'b1, 1'b1, blk[0]);
        tick();
        set_in(0, 1'b0, 1'b0, 1'b0, '0);
        repeat (6) tick();
        check("abort busy before reset", 512'(if0.busy), 512'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort ready",  512'(if0.msg_ready),    512'd0);
        check("abort busy",   512'(if0.busy),         512'd0);
        check("abort valid",  512'(if0.digest_valid), 512'd0);
        check("abort digest", if0.digest,             512'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_hash(0, "after_abort", 1, 160, 16, 160);

`ifdef CUBEHASH_IV_PRELOAD_EN
        if0.iv_load = 1'b1;
        if0.iv      = m_iv(512);
        set_in(0, 1'b1, 1'b0, 1'b0, '0);
        tick();
        set_in(0, 1'b0, 1'b0, 1'b0, '0);
        if0.iv_load = 1'b0;
        check("preload ready next cycle", 512'(if0.msg_ready), 512'd1);
        set_in(0, 1'b0, 1'b1, 1'b1, blk[0]);
        tick();
        set_in(0, 1'b0, 1'b0, 1'b0, '0);
        count_until(0, 1, n);
        check("preload absorb+final cycles", 512'(n), 512'd176);
        e = m_digest(512, 1);
        check("preload digest", if0.digest, e);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
